// File: rtl/bad_sync_pkg.sv
// Shared constants for the bad_synchronizer tile: counter width, output-select
// codes, the fixed uio_oe pattern and a modular difference helper.
package bad_sync_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        OSEL_EDGE = 2'd0,
        OSEL_REF  = 2'd1,
        OSEL_DIFF = 2'd2,
        OSEL_TAPS = 2'd3
    } osel_e;

    localparam logic [7:0] UIO_OE_VAL = 8'h1F;

    // Wrapping difference; the counters are free-running so only the low bits matter
    function automatic logic [CNT_W-1:0] cnt_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        cnt_diff = a - b;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Shift-register synchronizer; taps[0] is the first flop, taps[STAGES-1] the
// fully synchronized output.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d,
    output logic [STAGES-1:0] taps
);

    // Shift the asynchronous input one flop deeper every clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps <= {STAGES{1'b0}};
        end else begin
            taps <= {taps[STAGES-2:0], d};
        end
    end

endmodule

// File: rtl/bad_synchronizer.sv
// Metastability demo tile: counts edges on a selectable-depth synchronizer path
// and on a fixed 3-stage reference. Macro BAD_SYNC_RAW_PATH_EN makes depth 0 the raw input.
module bad_synchronizer #(
    parameter int CNT_W = bad_sync_pkg::CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    import bad_sync_pkg::*;

    logic [2:0]       in_taps;
    logic [1:0]       clr_taps;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             clr_sync;
    logic             sel_sig;
    logic             prev_sel;
    logic             prev_ref;
    logic             pulse;
    logic             ref_pulse;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] ref_cnt;
    logic             unused_inputs;

    assign unused_inputs = ^{uio_in, ui_in[7:6]};

    sync_chain #(.STAGES(3)) u_in_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (ui_in[0]),
        .taps (in_taps)
    );

    sync_chain #(.STAGES(2)) u_clr_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (ui_in[3]),
        .taps (clr_taps)
    );

    assign s1       = in_taps[0];
    assign s2       = in_taps[1];
    assign s3       = in_taps[2];
    assign clr_sync = clr_taps[1];

    // Pick the observed path by depth select
    always_comb begin
        sel_sig = s1;
        case (ui_in[2:1])
            2'd0: begin
`ifdef BAD_SYNC_RAW_PATH_EN
                sel_sig = ui_in[0];
`else
                sel_sig = s1;
`endif
            end
            2'd1:    sel_sig = s1;
            2'd2:    sel_sig = s2;
            2'd3:    sel_sig = s3;
            default: sel_sig = s1;
        endcase
    end

    assign pulse     = sel_sig & ~prev_sel;
    assign ref_pulse = s3 & ~prev_ref;

    // Edge-detect history flops run regardless of ena so re-enabling never fakes an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sel <= 1'b0;
            prev_ref <= 1'b0;
        end else begin
            prev_sel <= sel_sig;
            prev_ref <= s3;
        end
    end

    // Edge counters; synchronized clear beats both increment and ena
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= {CNT_W{1'b0}};
            ref_cnt  <= {CNT_W{1'b0}};
        end else if (clr_sync) begin
            edge_cnt <= {CNT_W{1'b0}};
            ref_cnt  <= {CNT_W{1'b0}};
        end else if (ena) begin
            if (pulse) begin
                edge_cnt <= edge_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                edge_cnt <= edge_cnt;
            end
            if (ref_pulse) begin
                ref_cnt <= ref_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                ref_cnt <= ref_cnt;
            end
        end else begin
            edge_cnt <= edge_cnt;
            ref_cnt  <= ref_cnt;
        end
    end

    // Pad view selected by ui_in[5:4]
    always_comb begin
        uo_out = 8'h00;
        case (osel_e'(ui_in[5:4]))
            OSEL_EDGE: uo_out = edge_cnt;
            OSEL_REF:  uo_out = ref_cnt;
            OSEL_DIFF: uo_out = cnt_diff(edge_cnt, ref_cnt);
            OSEL_TAPS: uo_out = {3'b000, pulse, sel_sig, s3, s2, s1};
            default:   uo_out = 8'h00;
        endcase
    end

    assign uio_out = {3'b000, pulse, sel_sig, s3, s2, s1};
    assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_bad_synchronizer.sv
// Scoreboard bench for bad_synchronizer: stimulus queues expected pad values,
// a negedge monitor drains and compares them.
module tb_bad_synchronizer;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct packed {
        logic [1:0] which;
        logic [7:0] exp;
        logic [7:0] mask;
    } item_t;

    item_t exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    bad_synchronizer #(.CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation against the pads at the falling edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            item_t it;
            string nm;
            logic [7:0] act;
            it = exp_q.pop_front();
            nm = name_q.pop_front();
            case (it.which)
                2'd0:    act = uo_out;
                2'd1:    act = uio_out;
                default: act = uio_oe;
            endcase
            n_checks++;
            if ((act & it.mask) !== (it.exp & it.mask)) begin
                n_fail++;
                $display("FAIL %s: got 8'h%02h expected 8'h%02h (mask 8'h%02h)",
                         nm, act, it.exp, it.mask);
            end
        end
    end

    task automatic expect_pad(input string nm, input logic [1:0] which,
                              input logic [7:0] exp, input logic [7:0] mask);
        item_t it;
        it.which = which;
        it.exp   = exp;
        it.mask  = mask;
        exp_q.push_back(it);
        name_q.push_back(nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Let the monitor sample the current state, then advance past the next edge
    task automatic sample();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string nm, input logic [1:0] osel, input logic [7:0] exp);
        ui_in[5:4] = osel;
        expect_pad(nm, 2'd0, exp, 8'hFF);
        sample();
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            ui_in[0] = 1'b1;
            idle(hi);
            ui_in[0] = 1'b0;
            idle(lo);
        end
    endtask

    task automatic do_reset(input logic [1:0] depth);
        ui_in    = 8'h00;
        ui_in[2:1] = depth;
        rst      = 1'b1;
        idle(2);
        rst      = 1'b0;
        idle(2);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'h00;
        rst    = 1'b1;
        idle(2);

        // Reset values under every output select, while still in reset
        for (int s = 0; s < 4; s++) begin
            check_out("reset_uo", 2'(s), 8'h00);
        end
        expect_pad("reset_uio_out", 2'd1, 8'h00, 8'hFF);
        expect_pad("reset_uio_oe", 2'd2, 8'h1F, 8'hFF);
        sample();
        rst = 1'b0;
        idle(1);
        check_out("post_reset_edge", 2'd0, 8'h00);

        // Depth 2, five clean pulses
        do_reset(2'd2);
        pulses(5, 4, 4);
        idle(6);
        check_out("d2_edge_cnt", 2'd0, 8'd5);
        check_out("d2_ref_cnt", 2'd1, 8'd5);
        check_out("d2_diff", 2'd2, 8'd0);

        // Latency per depth: edge_cnt reaches 1 after edge E<lat>
        for (int d = 0; d < 4; d++) begin
            do_reset(2'(d));
`ifdef BAD_SYNC_RAW_PATH_EN
            lat = d + 1;
`else
            lat = (d == 0) ? 2 : d + 1;
`endif
            ui_in[5:4] = 2'd0;
            ui_in[0]   = 1'b1;
            idle(1);
            for (int k = 1; k <= 5; k++) begin
                expect_pad($sformatf("lat_d%0d_E%0d", d, k), 2'd0,
                           (k >= lat) ? 8'd1 : 8'd0, 8'hFF);
                sample();
            end
            ui_in[0] = 1'b0;
            idle(6);
            check_out($sformatf("lat_d%0d_ref", d), 2'd1, 8'd1);
        end

        // Wrap: 257 pulses at depth 1
        do_reset(2'd1);
        pulses(257, 2, 2);
        idle(6);
        check_out("wrap_edge", 2'd0, 8'd1);
        check_out("wrap_ref", 2'd1, 8'd1);
        check_out("wrap_diff", 2'd2, 8'd0);

        // ena low freezes both counters
        ena = 1'b0;
        pulses(3, 4, 4);
        idle(6);
        ena = 1'b1;
        idle(2);
        check_out("ena_edge", 2'd0, 8'd1);
        check_out("ena_ref", 2'd1, 8'd1);

        // Clear request: counters read 0 only after the third edge
        ui_in[5:4] = 2'd0;
        ui_in[3]   = 1'b1;
        idle(1);
        ui_in[3]   = 1'b0;
        expect_pad("clr_E1", 2'd0, 8'd1, 8'hFF);
        sample();
        expect_pad("clr_E2", 2'd0, 8'd1, 8'hFF);
        sample();
        expect_pad("clr_E3", 2'd0, 8'd0, 8'hFF);
        sample();
        check_out("clr_ref", 2'd1, 8'd0);

        // One pulse after clear; diff shows edge path leading the reference
        ui_in[5:4] = 2'd2;
        ui_in[0]   = 1'b1;
        idle(1);
        for (int k = 1; k <= 4; k++) begin
            expect_pad($sformatf("post_clr_diff_E%0d", k), 2'd0,
                       (k == 2 || k == 3) ? 8'd1 : 8'd0, 8'hFF);
            sample();
        end
        ui_in[0] = 1'b0;
        idle(6);
        check_out("post_clr_edge", 2'd0, 8'd1);
        check_out("post_clr_ref", 2'd1, 8'd1);

        // Taps at depth 3: s1, s2, s3 rise on successive edges
        do_reset(2'd3);
        ui_in[5:4] = 2'd3;
        ui_in[0]   = 1'b1;
        idle(1);
        expect_pad("taps_E1_uo", 2'd0, 8'h01, 8'hFF);
        expect_pad("taps_E1_uio", 2'd1, 8'h01, 8'hFF);
        sample();
        expect_pad("taps_E2_uo", 2'd0, 8'h03, 8'hFF);
        expect_pad("taps_E2_uio", 2'd1, 8'h03, 8'hFF);
        sample();
        expect_pad("taps_E3_uo", 2'd0, 8'h1F, 8'hFF);
        expect_pad("taps_E3_uio", 2'd1, 8'h1F, 8'hFF);
        sample();
        expect_pad("taps_E4_uo", 2'd0, 8'h0F, 8'hFF);
        sample();
        ui_in[0] = 1'b0;
        idle(6);

        // Reset mid-count clears immediately
        ui_in[5:4] = 2'd0;
        rst = 1'b1;
        #1;
        check_out("midreset_edge", 2'd0, 8'd0);
        check_out("midreset_ref", 2'd1, 8'd0);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
